// File: rtl/decoder_3to8_seq.sv
// Registered binary-to-one-hot decoder with a direct valid/ready mode and a
// walking-bit scan mode; every one-hot value is held for HOLD_CYCLES cycles.
module decoder_3to8_seq #(
  parameter int CODE_W      = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 in_valid,
  input  logic [CODE_W-1:0]    in_code,
  output logic                 in_ready,
  output logic [2**CODE_W-1:0] y,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int N     = 2**CODE_W;
  // HOLD_CYCLES=1 would give a zero-width counter; keep one bit that never leaves 0.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   scan_idx_q, scan_idx_d;
  logic [N-1:0]        y_q, y_d;
  logic                out_valid_q, out_valid_d;
  logic                cnt_zero, handshake;

  always_comb begin
    cnt_zero   = (cnt_q == '0);
    in_ready   = en & ~mode & ((state_q == IDLE) | ((state_q == HOLD) & cnt_zero));
    handshake  = in_valid & in_ready;
    state_d    = state_q;
    cnt_d      = cnt_q;
    scan_idx_d = scan_idx_q;
    y_d        = y_q;
    if (!en) begin
      state_d = IDLE;
      y_d     = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (handshake) begin
            y_d     = N'(1) << in_code;
            cnt_d   = CNT_RELOAD;
            state_d = HOLD;
          end else if (mode) begin
            y_d        = N'(1);
            scan_idx_d = '0;
            cnt_d      = CNT_RELOAD;
            state_d    = SCAN;
          end
        end
        HOLD: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
          end else if (handshake) begin
            // Reload on the boundary so consecutive codes have no zero gap.
            y_d   = N'(1) << in_code;
            cnt_d = CNT_RELOAD;
          end else begin
            y_d     = '0;
            state_d = IDLE;
          end
        end
        SCAN: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
          end else if (mode) begin
            scan_idx_d = scan_idx_q + 1'b1;
            y_d        = N'(1) << scan_idx_d;
            cnt_d      = CNT_RELOAD;
          end else begin
            y_d     = '0;
            state_d = IDLE;
          end
        end
        default: begin
          y_d     = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    out_valid_d = |y_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      scan_idx_q  <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scan_idx_q  <= scan_idx_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

endmodule
